// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard/stall sequencer.
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        STALL_LU = 2'd1,
        MEM_WAIT = 2'd2
    } hz_state_t;

    localparam logic [4:0]  REG_ZERO  = 5'd0;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    // A load in EX targets a register the ID instruction reads ($zero never counts).
    function automatic logic load_use_hit(
        input logic       mem_read,
        input logic [4:0] ex_rt,
        input logic [4:0] id_rs,
        input logic [4:0] id_rt,
        input logic       uses_rt
    );
        return mem_read && (ex_rt != REG_ZERO) &&
               ((ex_rt == id_rs) || ((ex_rt == id_rt) && uses_rt));
    endfunction

endpackage

// File: rtl/hazard_controller_sat_counter.sv
// Saturating up-counter used for the stall and flush performance counters.
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    // Count qualified cycles, sticking at all-ones.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + WIDTH'(1);
        end else begin
            count <= count;
        end
    end

endmodule

// File: rtl/hazard_controller.sv
// Hazard and stall sequencer for the 5-stage core: load-use stalls, branch/jump
// squashing, memory wait freezes, a sticky wait timeout and performance counters.
module hazard_controller
    import hazard_pkg::*;
#(
    parameter int LOAD_USE_STALL = 1,
    parameter int WAIT_TIMEOUT   = 255,
    parameter int CNT_W          = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       if_id_rs,
    input  logic [4:0]       if_id_rt,
    input  logic             if_id_uses_rt,
    input  logic             id_ex_mem_read,
    input  logic [4:0]       id_ex_rt,
    input  logic             branch_taken,
    input  logic             jump_id,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic             pc_write,
    output logic             if_id_enable,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output logic             pipe_freeze,
    output logic             timeout_error,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    localparam int              WT_W      = $clog2(WAIT_TIMEOUT + 1);
    localparam logic [WT_W-1:0] WT_MAX    = WT_W'(WAIT_TIMEOUT);
    localparam logic [1:0]      LU_RELOAD = 2'(LOAD_USE_STALL - 1);

    hz_state_t       state_r, next_state_s, ret_state_r, next_ret_s, eff_state_s;
    logic [1:0]      lu_cnt_r, next_lu_cnt_s;
    logic [WT_W-1:0] wait_cnt_r, wait_next_s;
    logic            timeout_r;
    logic            freeze_s, lu_s, lu_stall_s;
    logic            pc_write_s, if_id_enable_s, if_id_flush_s, id_ex_bubble_s, pipe_freeze_s;

    assign freeze_s = !imem_ready || !dmem_ready;
    assign lu_s     = load_use_hit(id_ex_mem_read, id_ex_rt, if_id_rs, if_id_rt, if_id_uses_rt);

    // Priority resolution of the control outputs and FSM next state.
    always_comb begin
        pc_write_s     = 1'b0;
        if_id_enable_s = 1'b0;
        if_id_flush_s  = 1'b0;
        id_ex_bubble_s = 1'b0;
        pipe_freeze_s  = 1'b0;
        next_state_s   = state_r;
        next_ret_s     = ret_state_r;
        next_lu_cnt_s  = lu_cnt_r;
        // The wake-up cycle out of MEM_WAIT behaves as the state that was left,
        // except that a fresh load-use is not detected there.
        eff_state_s    = (state_r == MEM_WAIT) ? ret_state_r : state_r;
        lu_stall_s     = (eff_state_s == STALL_LU) || ((state_r == RUN) && lu_s);

        if (freeze_s) begin
            pipe_freeze_s = 1'b1;
            next_state_s  = MEM_WAIT;
            if (state_r != MEM_WAIT) begin
                next_ret_s = state_r;
            end else begin
                next_ret_s = ret_state_r;
            end
        end else if (branch_taken) begin
            pc_write_s     = 1'b1;
            if_id_enable_s = 1'b1;
            if_id_flush_s  = 1'b1;
            id_ex_bubble_s = 1'b1;
            next_state_s   = RUN;
            next_lu_cnt_s  = 2'd0;
        end else if (jump_id) begin
            // The ID instruction is replaced anyway, so an owed stall is dropped.
            pc_write_s     = 1'b1;
            if_id_enable_s = 1'b1;
            if_id_flush_s  = 1'b1;
            next_state_s   = RUN;
            next_lu_cnt_s  = 2'd0;
        end else if (lu_stall_s) begin
            id_ex_bubble_s = 1'b1;
            if (eff_state_s == STALL_LU) begin
                if (lu_cnt_r == 2'd1) begin
                    next_state_s  = RUN;
                    next_lu_cnt_s = 2'd0;
                end else begin
                    next_state_s  = STALL_LU;
                    next_lu_cnt_s = lu_cnt_r - 2'd1;
                end
            end else if (LOAD_USE_STALL > 1) begin
                next_state_s  = STALL_LU;
                next_lu_cnt_s = LU_RELOAD;
            end else begin
                next_state_s  = RUN;
            end
        end else begin
            pc_write_s     = 1'b1;
            if_id_enable_s = 1'b1;
            next_state_s   = RUN;
        end
    end

    // FSM state, saved return state and remaining load-use stall count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= RUN;
            ret_state_r <= RUN;
            lu_cnt_r    <= 2'd0;
        end else begin
            state_r     <= next_state_s;
            ret_state_r <= next_ret_s;
            lu_cnt_r    <= next_lu_cnt_s;
        end
    end

    // Consecutive freeze cycles, saturating at the timeout threshold.
    always_comb begin
        if (!freeze_s) begin
            wait_next_s = '0;
        end else if (wait_cnt_r == WT_MAX) begin
            wait_next_s = WT_MAX;
        end else begin
            wait_next_s = wait_cnt_r + WT_W'(1);
        end
    end

    // Wait counter and sticky timeout flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt_r <= '0;
            timeout_r  <= 1'b0;
        end else begin
            wait_cnt_r <= wait_next_s;
            timeout_r  <= timeout_r || (freeze_s && (wait_next_s == WT_MAX));
        end
    end

    sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (!pc_write_s),
        .count (stall_cycles)
    );

    sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (if_id_flush_s),
        .count (flush_count)
    );

    // Controls are forced inactive for as long as reset is held.
    assign pc_write      = reset & pc_write_s;
    assign if_id_enable  = reset & if_id_enable_s;
    assign if_id_flush   = reset & if_id_flush_s;
    assign id_ex_bubble  = reset & id_ex_bubble_s;
    assign pipe_freeze   = reset & pipe_freeze_s;
    assign timeout_error = timeout_r;

endmodule

// File: doc/hazard_controller.md
# hazard_controller

Pipeline hazard and stall sequencer for the 5-stage MIPS core. It drives the IF/ID register's `enable`, a NOP-insert flush for IF/ID, the PC write enable, an ID/EX bubble, and a global pipeline freeze. It resolves four conditions: load-use hazards, taken branches from EX, jumps in ID, and instruction/data memory wait states. It also keeps saturating stall and flush performance counters and a sticky memory-timeout flag.

## Interface
- `LOAD_USE_STALL`, default 1: stall cycles per load-use hazard, legal 1..3. Set 2 when EX forwarding is absent.
- `WAIT_TIMEOUT`, default 255: consecutive freeze cycles before `timeout_error` sets.
- `CNT_W`, default 32: width of the performance counters.
- `clk` in 1: clock.
- `reset` in 1: asynchronous, active-low.
- `if_id_rs` in 5: rs field of the instruction in ID.
- `if_id_rt` in 5: rt field of the instruction in ID.
- `if_id_uses_rt` in 1: the ID instruction reads rt (R-type, beq/bne, sw).
- `id_ex_mem_read` in 1: the EX instruction is a load.
- `id_ex_rt` in 5: destination register of the load in EX.
- `branch_taken` in 1: the branch in EX resolved taken.
- `jump_id` in 1: the ID instruction is j or jal.
- `imem_ready` in 1: instruction memory data valid this cycle.
- `dmem_ready` in 1: data memory access complete this cycle.
- `pc_write` out 1: PC load enable.
- `if_id_enable` out 1: drives the IF/ID register `enable`.
- `if_id_flush` out 1: forces IF/ID `instruction_in` to 32'h0 (NOP).
- `id_ex_bubble` out 1: zero the ID/EX control fields.
- `pipe_freeze` out 1: hold the ID/EX, EX/MEM and MEM/WB registers.
- `timeout_error` out 1: sticky; a memory wait exceeded `WAIT_TIMEOUT`.
- `stall_cycles` out CNT_W: count of cycles with `pc_write`=0.
- `flush_count` out CNT_W: count of cycles with `if_id_flush`=1.

## Operation
- Hazard `lu` is true when `id_ex_mem_read` is high, `id_ex_rt` is not 0, and either `id_ex_rt`==`if_id_rs` or (`id_ex_rt`==`if_id_rt` and `if_id_uses_rt`).
- Output conditions are evaluated in priority order; the first match applies.
  1. Freeze, when `!imem_ready || !dmem_ready`:
     - `pipe_freeze`=1, `pc_write`=0, `if_id_enable`=0, `if_id_flush`=0, `id_ex_bubble`=0.
     - The FSM state and stall counter hold.
  2. `branch_taken`:
     - `pc_write`=1, `if_id_enable`=1, `if_id_flush`=1, `id_ex_bubble`=1.
     - Any pending load-use stall is cancelled and the FSM goes to RUN.
  3. `jump_id`: `pc_write`=1, `if_id_enable`=1, `if_id_flush`=1, `id_ex_bubble`=0.
  4. Load-use stall, when in state STALL_LU or when `lu` is true in RUN: `pc_write`=0, `if_id_enable`=0, `if_id_flush`=0, `id_ex_bubble`=1.
  5. Otherwise: `pc_write`=1, `if_id_enable`=1, everything else 0.
- FSM states:
  - RUN: on `lu` (priority 4 taken) with `LOAD_USE_STALL`>1, go to STALL_LU and load `lu_cnt`=`LOAD_USE_STALL`-1.
  - STALL_LU: decrement `lu_cnt` each unfrozen cycle. Return to RUN in the cycle after `lu_cnt`==1.
  - MEM_WAIT: entered from any state when a freeze starts; `ret_state` saves the state being left. Return to `ret_state` in the first cycle both ready signals are high. `lu` is not re-evaluated in that cycle.
- Wait counter:
  - Increments each MEM_WAIT cycle and clears on exit.
  - Reaching `WAIT_TIMEOUT` sets `timeout_error`, which clears only on reset.
  - The counter saturates at `WAIT_TIMEOUT`.
- Performance counters:
  - Increment on their condition each cycle and saturate at all-ones.
  - `stall_cycles` counts both freeze and load-use cycles.

## Timing
- All control outputs are combinational from the FSM state, counters and current inputs (Mealy), so they affect the same clock edge.
- Counters and `timeout_error` are registered and visible one cycle after the event.
- Reset values: state=RUN, all counters 0, `timeout_error`=0.
- Control outputs while reset is low, regardless of inputs: `pc_write`=0, `if_id_enable`=0, `if_id_flush`=0, `id_ex_bubble`=0, `pipe_freeze`=0.
- Reset asserted mid-stall or mid-wait aborts the operation immediately, with no pending state kept.
- Load-use penalty is exactly `LOAD_USE_STALL` unfrozen cycles, and frozen cycles do not consume it.
- Branch penalty is 2 squashed instructions (IF/ID flush plus ID/EX bubble); jump penalty is 1.

## Structure
- Shared package `hazard_pkg` holds:
  - the state enum `{RUN, STALL_LU, MEM_WAIT}`;
  - `REG_ZERO`=5'd0;
  - `NOP_INSTR`=32'h0.
- One sub-module, `sat_counter` (parameter width, `inc` input, saturating), instantiated twice for `stall_cycles` and `flush_count`.

## Test plan
- Load-use, default parameter. `lw $t0` in EX and `add $t1,$t0,$t2` in ID (`id_ex_rt`=8, `if_id_rs`=8) -> exactly 1 cycle of `pc_write`=0, `if_id_enable`=0, `id_ex_bubble`=1; `stall_cycles`=1.
- Load-use without forwarding. `LOAD_USE_STALL`=2, `id_ex_rt`=8 matching `if_id_rt`=8 with `if_id_uses_rt`=1 -> 2 stall cycles. Repeating with `id_ex_rt`=0 or `if_id_uses_rt`=0 -> no stall.
- Branch overrides load-use. `branch_taken` and `lu` asserted in the same cycle -> `if_id_flush`=1, `id_ex_bubble`=1, `pc_write`=1, state RUN next; `flush_count` increments by 1.
- Freeze during stall. `dmem_ready`=0 for 3 cycles in the middle of a 2-cycle STALL_LU -> 3 freeze cycles with `pipe_freeze`=1, then the remaining 1 stall cycle; `stall_cycles`=5.
- Timeout. `WAIT_TIMEOUT`=4, `imem_ready` held low for 6 cycles -> `timeout_error` rises after the 4th cycle and stays high after ready returns until `reset` pulses low.
- Reset mid-wait. Asynchronous `reset` low during MEM_WAIT -> outputs go to their reset values immediately, counters read 0, and the state is RUN on release.
